// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB completer memory with programmable wait states
//
// Word-addressed register file on an APB bus. Each transfer is a setup cycle
// followed by WAIT_STATES access cycles with Pready low, then one ACCESS cycle
// with Pready high. Misaligned or out-of-range addresses complete with Pslverr.
//
// Ports:
//   Pclk     APB clock, rising edge
//   Preset   synchronous active-high reset, clears state, outputs and memory
//   Psel     slave select
//   Penable  access-phase strobe
//   Pwrite   1 = write, 0 = read
//   Paddr    byte address (32 bits)
//   Pdata    write data
//   Prdata   read data, nonzero only in the ACCESS cycle of a good read
//   Pready   high for the single cycle in which a transfer completes
//   Pslverr  error response, high only with Pready on an error address
module apb_slave_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                  Pclk,
  input  logic                  Preset,
  input  logic                  Psel,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [31:0]           Paddr,
  input  logic [DATA_WIDTH-1:0] Pdata,
  output logic [DATA_WIDTH-1:0] Prdata,
  output logic                  Pready,
  output logic                  Pslverr
);

  localparam int AW = $clog2(DEPTH);
  localparam bit ZERO_WAIT = (WAIT_STATES == 0);
  // The counter holds the number of non-ready cycles still to run after the
  // current one, so the first access cycle (SETUP state) already counts as one.
  localparam logic [3:0] CNT_INIT = ZERO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, WAIT, ACCESS} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  latch, enter_access;

  logic [AW-1:0]         idx_q;
  logic                  wr_q, err_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  addr_err;
  logic [AW-1:0]         idx_acc;
  logic                  wr_acc, err_acc;

  assign addr_err = (|Paddr[1:0]) | (|Paddr[31:AW+2]);

  // With zero wait states ACCESS is entered straight from the setup edge, so
  // the response must come from the live bus rather than the latched copy.
  assign idx_acc = latch ? Paddr[AW+1:2] : idx_q;
  assign wr_acc  = latch ? Pwrite        : wr_q;
  assign err_acc = latch ? addr_err      : err_q;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    latch        = 1'b0;
    enter_access = 1'b0;
    case (state)
      IDLE: begin
        if (Psel && !Penable) begin
          latch   = 1'b1;
          cnt_nxt = CNT_INIT;
          if (ZERO_WAIT) begin
            state_nxt    = ACCESS;
            enter_access = 1'b1;
          end else begin
            state_nxt = SETUP;
          end
        end
      end
      SETUP: begin
        if (!Psel) begin
          state_nxt = IDLE;
        end else if (Penable) begin
          if (cnt == 4'd0) begin
            state_nxt    = ACCESS;
            enter_access = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = cnt - 4'd1;
          end
        end
      end
      WAIT: begin
        if (!Psel) begin
          state_nxt = IDLE;
        end else if (cnt == 4'd0) begin
          state_nxt    = ACCESS;
          enter_access = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ACCESS: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Pclk) begin
    if (Preset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      Pready  <= 1'b0;
      Pslverr <= 1'b0;
      Prdata  <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      if (latch) begin
        idx_q   <= Paddr[AW+1:2];
        wr_q    <= Pwrite;
        err_q   <= addr_err;
        wdata_q <= Pdata;
      end
      Pready  <= enter_access;
      Pslverr <= enter_access & err_acc;
      Prdata  <= (enter_access && !wr_acc && !err_acc) ? mem[idx_acc] : '0;
    end
  end

  // Writes commit at the edge that ends ACCESS, before any following setup.
  always_ff @(posedge Pclk) begin
    if (Preset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == ACCESS && wr_q && !err_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - bench for apb_slave_mem with 2-wait and 0-wait instances
module tb_apb_slave_mem;

  logic        clk;
  logic        preset;
  logic [1:0]  psel, penable, pwrite;
  logic [31:0] paddr [2];
  logic [31:0] pdata [2];

  logic [31:0] rdata0, rdata1;
  logic        rdy0, rdy1, serr0, serr1;

  logic [1:0]  exp_ready, exp_err, exp_rd;
  logic [31:0] exp_rdata [2];
  logic [31:0] model_mem [2][16];

  int vectors;
  int miscompares;
  bit check_on;

  apb_slave_mem #(.DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(2)) dut0 (
    .Pclk(clk), .Preset(preset), .Psel(psel[0]), .Penable(penable[0]),
    .Pwrite(pwrite[0]), .Paddr(paddr[0]), .Pdata(pdata[0]),
    .Prdata(rdata0), .Pready(rdy0), .Pslverr(serr0)
  );

  apb_slave_mem #(.DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(0)) dut1 (
    .Pclk(clk), .Preset(preset), .Psel(psel[1]), .Penable(penable[1]),
    .Pwrite(pwrite[1]), .Paddr(paddr[1]), .Pdata(pdata[1]),
    .Prdata(rdata1), .Pready(rdy1), .Pslverr(serr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic get_rdy(input int d);
    return (d == 0) ? rdy0 : rdy1;
  endfunction

  function automatic logic get_err(input int d);
    return (d == 0) ? serr0 : serr1;
  endfunction

  function automatic logic [31:0] get_rdata(input int d);
    return (d == 0) ? rdata0 : rdata1;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the bench's expectations.
  always @(negedge clk) begin
    if (check_on) begin
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (get_rdy(d) !== exp_ready[d]) begin
          miscompares++;
          $display("FAIL pready dut%0d: got %b expected %b at %0t", d, get_rdy(d), exp_ready[d], $time);
        end
        vectors++;
        if (get_err(d) !== (exp_ready[d] & exp_err[d])) begin
          miscompares++;
          $display("FAIL pslverr dut%0d: got %b expected %b at %0t", d, get_err(d), exp_ready[d] & exp_err[d], $time);
        end
        if (!exp_ready[d] || exp_rd[d]) begin
          vectors++;
          if (get_rdata(d) !== (exp_ready[d] ? exp_rdata[d] : 32'h0)) begin
            miscompares++;
            $display("FAIL prdata dut%0d: got %h expected %h at %0t", d, get_rdata(d),
                     exp_ready[d] ? exp_rdata[d] : 32'h0, $time);
          end
        end
      end
    end
  end

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) model_mem[d][i] = 32'h0;
  endtask

  task automatic go_idle(input int d);
    psel[d] = 1'b0; penable[d] = 1'b0;
    exp_ready[d] = 1'b0; exp_err[d] = 1'b0; exp_rd[d] = 1'b0;
  endtask

  task automatic do_reset(input int n);
    preset = 1'b1;
    go_idle(0); go_idle(1);
    repeat (n) begin @(posedge clk); #1; end
    preset = 1'b0;
    clear_model();
  endtask

  // One complete transfer; returns what the DUT showed in its ready cycle.
  // Bus signals are scrambled after setup to show the latched copy is used.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, output logic [31:0] rd, output logic es);
    int  w;
    bit  err;
    w   = (d == 0) ? 2 : 0;
    err = (addr[1:0] != 2'b00) || (addr[31:6] != 26'h0);
    rd  = 32'hx;
    es  = 1'bx;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pdata[d] = data;
    exp_ready[d] = 1'b0; exp_err[d] = 1'b0; exp_rd[d] = 1'b0;
    @(posedge clk); #1;
    penable[d] = 1'b1; pwrite[d] = ~wr; paddr[d] = ~addr; pdata[d] = ~data;
    for (int k = 0; k <= w; k++) begin
      if (k == w) begin
        exp_ready[d] = 1'b1;
        exp_err[d]   = err;
        exp_rd[d]    = !wr;
        exp_rdata[d] = err ? 32'h0 : model_mem[d][addr[5:2]];
        @(negedge clk);
        rd = get_rdata(d);
        es = get_err(d);
      end
      @(posedge clk); #1;
    end
    if (wr && !err) model_mem[d][addr[5:2]] = data;
    go_idle(d);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  logic [31:0] rd;
  logic        es;

  initial begin
    vectors = 0; miscompares = 0; check_on = 1'b1;
    preset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      pwrite[d] = 1'b0; paddr[d] = 32'h0; pdata[d] = 32'h0; exp_rdata[d] = 32'h0;
    end
    go_idle(0); go_idle(1);
    clear_model();

    // Reset then idle
    do_reset(2);
    check("reset_pready", {31'h0, rdy0}, 32'h0);
    check("reset_prdata", rdata0, 32'h0);
    check("reset_pslverr", {31'h0, serr0}, 32'h0);
    xfer(0, 1'b0, 32'h08, 32'h0, rd, es);
    check("read_after_reset", rd, 32'h0);

    // Two wait states: write then read
    xfer(0, 1'b1, 32'h04, 32'hDEADBEEF, rd, es);
    xfer(0, 1'b0, 32'h04, 32'h0, rd, es);
    check("ws2_read_04", rd, 32'hDEADBEEF);
    check("ws2_read_04_err", {31'h0, es}, 32'h0);

    // Error addresses must not alias into word 0
    xfer(0, 1'b1, 32'h00, 32'hCAFEF00D, rd, es);
    xfer(0, 1'b1, 32'h40, 32'h99999999, rd, es);
    check("err_write_40", {31'h0, es}, 32'h1);
    xfer(0, 1'b0, 32'h41, 32'h0, rd, es);
    check("err_read_41", {31'h0, es}, 32'h1);
    check("err_read_41_data", rd, 32'h0);
    xfer(0, 1'b0, 32'h00, 32'h0, rd, es);
    check("word0_unchanged", rd, 32'hCAFEF00D);
    idle_cycles(2);

    // Penable without a setup cycle is ignored
    psel[1] = 1'b1; penable[1] = 1'b1; pwrite[1] = 1'b1; paddr[1] = 32'h0; pdata[1] = 32'hFFFFFFFF;
    idle_cycles(2);
    go_idle(1);
    idle_cycles(1);

    // Zero wait states, back-to-back with no idle cycles
    xfer(1, 1'b1, 32'h00, 32'h11111111, rd, es);
    xfer(1, 1'b1, 32'h3C, 32'h22222222, rd, es);
    xfer(1, 1'b0, 32'h00, 32'h0, rd, es);
    check("ws0_read_00", rd, 32'h11111111);
    xfer(1, 1'b0, 32'h3C, 32'h0, rd, es);
    check("ws0_read_3c", rd, 32'h22222222);
    idle_cycles(1);

    // Abort during WAIT leaves memory unchanged
    xfer(0, 1'b1, 32'h08, 32'h13572468, rd, es);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h08; pdata[0] = 32'h55AA55AA;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    @(posedge clk); #1;
    go_idle(0);
    idle_cycles(2);
    xfer(0, 1'b0, 32'h08, 32'h0, rd, es);
    check("abort_read_08", rd, 32'h13572468);

    // Read-after-write back-to-back, then reset during WAIT of a write
    xfer(0, 1'b1, 32'h0C, 32'h12345678, rd, es);
    xfer(0, 1'b0, 32'h0C, 32'h0, rd, es);
    check("raw_read_0c", rd, 32'h12345678);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h0C; pdata[0] = 32'h9ABCDEF0;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    @(posedge clk); #1;
    preset = 1'b1;
    @(posedge clk); #1;
    preset = 1'b0;
    go_idle(0);
    clear_model();
    idle_cycles(2);
    xfer(0, 1'b0, 32'h0C, 32'h0, rd, es);
    check("reset_mid_read_0c", rd, 32'h0);
    xfer(1, 1'b0, 32'h3C, 32'h0, rd, es);
    check("reset_mid_read_3c", rd, 32'h0);
    idle_cycles(2);

    check_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB completer (slave) memory that answers the APB master side of the AHB-to-APB bridge on the same APB bus. It decodes Psel/Penable/Paddr/Pwrite/Pdata, holds a small word-addressed register file, inserts a parameterised number of wait states via Pready, and returns Prdata and an error flag. It is the bus-end peripheral the bridge is verified against and the template for real peripherals.

## Interface
- DATA_WIDTH, 32, width of Pdata/Prdata and of each storage word
- DEPTH, 16, number of 32-bit words; power of two, 2..256
- WAIT_STATES, 1, access-phase cycles with Pready low before completion; 0..15
- Pclk  input  1  APB clock; all logic on rising edge
- Preset  input  1  synchronous, active-high reset
- Psel  input  1  slave select
- Penable  input  1  access-phase strobe
- Pwrite  input  1  1 = write, 0 = read
- Paddr  input  32  byte address
- Pdata  input  DATA_WIDTH  write data
- Prdata  output  DATA_WIDTH  read data, valid only while Pready=1 on a read
- Pready  output  1  transfer completes in the current cycle
- Pslverr  output  1  error response, valid only while Pready=1

## Operation
- Word index = Paddr[log2(DEPTH)+1:2]. Error address: Paddr[1:0] != 0, or any bit of Paddr[31:log2(DEPTH)+2] set.
- FSM states: IDLE, SETUP, WAIT, ACCESS.
  - IDLE: Psel=1 and Penable=0 -> SETUP; latch Paddr, Pwrite, Pdata, error flag; load wait counter with WAIT_STATES.
  - SETUP (first access cycle pending): Psel=1, Penable=1 -> ACCESS if counter=0, else WAIT.
  - WAIT: counter decrements by 1 per cycle; reaching 0 -> ACCESS.
  - ACCESS: Pready=1 for exactly one cycle; next state IDLE, or SETUP if Psel=1 and Penable=0 at that edge (back-to-back).
- Outputs Pready, Prdata, Pslverr are registered; register values for the ACCESS cycle are loaded at the edge entering ACCESS.
- Write: memory word updated at the edge ending the ACCESS cycle, using latched address/data; no write on error address.
- Read: Prdata = mem[latched index]; error address -> Prdata=0, Pslverr=1.
- Pslverr=1 for the ACCESS cycle of any error-address transfer, read or write; 0 otherwise.
- Address/data/Pwrite changes after the setup cycle are ignored; latched values are used.
- Abort: Psel=0 in SETUP or WAIT -> IDLE next cycle, no write, Pready never asserted.
- Penable=1 while in IDLE (no setup seen): ignored, stays IDLE.
- Reset: state IDLE, counter 0, all memory words 0.

## Timing
- Reset values: Pready=0, Prdata=0, Pslverr=0.
- Outside ACCESS: Pready=0, Prdata=0, Pslverr=0.
- Latency, setup edge to completion: transfer occupies 2+WAIT_STATES cycles (1 setup + 1+WAIT_STATES access); Pready high in the last one.
- WAIT_STATES=0: Pready high in the first Penable cycle (zero-wait APB).
- Back-to-back: next setup cycle may immediately follow ACCESS; sustained rate one transfer per 2+WAIT_STATES cycles.
- Read-after-write same address back-to-back returns new data (write commits before the following setup edge).
- Preset=1 in any cycle, including WAIT or ACCESS: at that edge outputs go to reset values, pending write is dropped, state IDLE; Preset has priority over all inputs.

## Test plan
- Reset then idle: Preset=1 for 2 cycles -> Pready=0, Prdata=0, Pslverr=0; read of 0x08 returns 0x00000000.
- WAIT_STATES=2: write 0xDEADBEEF to 0x04, read 0x04 -> each transfer 4 cycles, Pready high only in 4th, read returns 0xDEADBEEF, Pslverr=0.
- Error addresses (DEPTH=16): write 0x40, read 0x41 -> Pslverr=1 with Pready, Prdata=0; subsequent read of 0x00 unchanged.
- WAIT_STATES=0 back-to-back: write 0x11111111 @0x0, write 0x22222222 @0x3C, read 0x0, read 0x3C with no idle cycles -> 2 cycles each, reads return 0x11111111, 0x22222222.
- Abort: setup write 0x55AA55AA @0x08, drop Psel during WAIT -> no Pready, later read of 0x08 returns previous value.
- Reset mid-operation: Preset=1 during WAIT of a write to 0x0C -> Pready stays 0, read of 0x0C after reset returns 0.
